// File: rtl/dma_bus_arbiter.sv
// Shares the synchronous memory bus between the 6502 core and a 256-byte page-copy DMA engine.
// A CPU write to DMA_REG halts the core, copies page {P,00..FF} to DST_ADDR, then hands the
// bus back to the core after re-issuing its stalled read address.
// Optional feature: define DMA_ALIGN_EN to insert one ALIGN cycle so copies start on a fixed
// parity phase (parity register present only in that build).
module dma_bus_arbiter #(
    parameter logic [15:0] DMA_REG  = 16'h4014,
    parameter logic [15:0] DST_ADDR = 16'h2004
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_o,
    input  logic        cpu_rw,
    output logic [7:0]  cpu_data_i,
    output logic        cpu_ready,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_rw,
    input  logic [7:0]  mem_rdata,
    output logic        dma_active
);

`ifdef DMA_ALIGN_EN
    typedef enum logic [2:0] {StIdle, StHalt, StRd, StWr, StResume, StAlign} state_e;
`else
    typedef enum logic [2:0] {StIdle, StHalt, StRd, StWr, StResume} state_e;
`endif

    state_e     state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic       trig;

`ifdef DMA_ALIGN_EN
    logic parity_q;

    // Free-running cycle parity; 0 in the first cycle after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ~parity_q;
        end
    end
`endif

    assign trig = !cpu_rw && (cpu_addr == DMA_REG);

    // State, source page and byte index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic; a repeated trigger while halted overwrites the page (last one wins).
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        case (state_q)
            StIdle: begin
                if (trig) begin
                    page_d  = cpu_data_o;
                    state_d = StHalt;
                end
            end
            StHalt: begin
                if (trig) begin
                    page_d = cpu_data_o;
                end
                // The core ignores ready during writes, so only a read means it has stopped.
                if (cpu_rw) begin
`ifdef DMA_ALIGN_EN
                    state_d = parity_q ? StAlign : StRd;
`else
                    state_d = StRd;
`endif
                end
            end
`ifdef DMA_ALIGN_EN
            StAlign: state_d = StRd;
`endif
            StRd: state_d = StWr;
            StWr: begin
                if (idx_q == 8'hFF) begin
                    idx_d   = 8'h00;
                    state_d = StResume;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = StRd;
                end
            end
            StResume: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Bus mux: DMA owns the bus only in RD/WR; RESUME re-issues the core's pending address.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_data_o;
        mem_rw    = cpu_rw;
        case (state_q)
            StRd: begin
                mem_addr = {page_q, idx_q};
                mem_rw   = 1'b1;
            end
            StWr: begin
                mem_addr  = DST_ADDR;
                mem_wdata = mem_rdata;
                mem_rw    = 1'b0;
            end
            default: ;
        endcase
    end

    // Status outputs decode registered state only.
    always_comb begin
        cpu_ready  = (state_q == StIdle);
        dma_active = (state_q != StIdle);
        cpu_data_i = mem_rdata;
    end

endmodule
